// File: rtl/mips_muldiv_pkg.sv
// rtl/mips_muldiv_pkg.sv - op encodings, FSM states and helpers for the mul/div unit
package mips_muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    // Magnitude of a w-bit two's complement value held in the low bits of v.
    // The most negative value maps to its unsigned magnitude 2^(w-1).
    function automatic logic [63:0] abs_w(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        if (((v >> (w - 1)) & 64'd1) != 64'd0)
            return (~v + 64'd1) & mask;
        return v & mask;
    endfunction

    // Ops that run through the multi-cycle datapath (MUL/DIV/MAC).
    function automatic logic op_is_muldiv(input logic [3:0] o);
        return o <= OP_MSUBU;
    endfunction

    function automatic logic op_is_div(input logic [3:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_mac(input logic [3:0] o);
        return (o >= OP_MADD) && (o <= OP_MSUBU);
    endfunction

    function automatic logic op_is_sub(input logic [3:0] o);
        return (o == OP_MSUB) || (o == OP_MSUBU);
    endfunction

    function automatic logic op_signed(input logic [3:0] o);
        return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_step.sv
// rtl/mips_muldiv_unit_step.sv - one combinational shift-add / restoring-divide iteration
// Ports:
//   div_mode  in   0: multiply step, 1: divide step
//   part_in   in   partial product {acc, multiplier} or partial {remainder, quotient}
//   operand   in   multiplicand (mult) or divisor (div)
//   part_out  out  next partial value (divide: quotient bit position left 0)
//   q_bit     out  quotient bit produced by this divide step (0 in multiply mode)
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   part_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   part_out,
    output logic                 q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        part_out = part_in;
        q_bit    = 1'b0;
        sum      = '0;
        trial    = '0;
        diff     = '0;
        if (!div_mode) begin
            // Add multiplicand into the upper half when the current multiplier
            // LSB is set, then shift the whole product right (carry enters top).
            sum      = {1'b0, part_in[2*WIDTH-1:WIDTH]} + (part_in[0] ? {1'b0, operand} : '0);
            part_out = {sum, part_in[WIDTH-1:1]};
        end else begin
            // Upper half after a left shift of {rem, quo}; needs one extra bit.
            trial    = part_in[2*WIDTH-1:WIDTH-1];
            diff     = trial - {1'b0, operand};
            q_bit    = ~diff[WIDTH];
            part_out = {(q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), part_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - multi-cycle multiply/divide/MAC unit owning HI/LO
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start, op       op request (accepted when start && ready && !flush), opcode
//   rs_val, rt_val  operand A / operand B
//   flush           abort in-flight op; also blocks an accept in the same cycle
//   ready, busy     idle / op in flight
//   done            one-cycle pulse after HI/LO written by a multi-cycle op
//   hi, lo          architectural HI/LO registers
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit ENABLE_MAC = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] part, part_nx;
    logic               q_bit;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   dividend_raw;
    logic [3:0]         op_q;
    logic               neg_q, neg_r, div_zero;

    logic               op_ok, accept_op, accept_mt;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_s, mac_sum;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    assign op_ok     = op_is_muldiv(op) && (ENABLE_MAC || !op_is_mac(op));
    assign accept_op = start && ready && !flush && op_ok;
    assign accept_mt = start && ready && !flush && ((op == OP_MTHI) || (op == OP_MTLO));

    assign sign_a = op_signed(op) && rs_val[WIDTH-1];
    assign sign_b = op_signed(op) && rt_val[WIDTH-1];
    assign abs_a  = op_signed(op) ? WIDTH'(abs_w(64'(rs_val), WIDTH)) : rs_val;
    assign abs_b  = op_signed(op) ? WIDTH'(abs_w(64'(rt_val), WIDTH)) : rt_val;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (op_is_div(op_q)),
        .part_in  (part),
        .operand  (operand),
        .part_out (part_nx),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept_op) state_nx = S_CALC;
            S_CALC:  if (flush) state_nx = S_IDLE;
                     else if (cnt == CW'(1)) state_nx = S_FIXUP;
            S_FIXUP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == S_IDLE);
        busy  = (state != S_IDLE);
    end

    // Sign correction and accumulate, evaluated on the FIXUP cycle. The signed
    // overflow divide (-2^(W-1) / -1) needs no special case: the magnitude
    // quotient 2^(W-1) is left un-negated and reads back as -2^(W-1), rem 0.
    always_comb begin
        prod_s  = neg_q ? -part : part;
        mac_sum = '0;
        hi_fix  = hi;
        lo_fix  = lo;
        if (op_is_div(op_q)) begin
            if (div_zero) begin
                lo_fix = '1;
                hi_fix = dividend_raw;
            end else begin
                lo_fix = neg_q ? -part[WIDTH-1:0] : part[WIDTH-1:0];
                hi_fix = neg_r ? -part[2*WIDTH-1:WIDTH] : part[2*WIDTH-1:WIDTH];
            end
        end else if (op_is_mac(op_q)) begin
            mac_sum = op_is_sub(op_q) ? ({hi, lo} - prod_s) : ({hi, lo} + prod_s);
            hi_fix  = mac_sum[2*WIDTH-1:WIDTH];
            lo_fix  = mac_sum[WIDTH-1:0];
        end else begin
            hi_fix = prod_s[2*WIDTH-1:WIDTH];
            lo_fix = prod_s[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi           <= '0;
            lo           <= '0;
            done         <= 1'b0;
            cnt          <= '0;
            part         <= '0;
            operand      <= '0;
            dividend_raw <= '0;
            op_q         <= OP_MULT;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_mt) begin
                if (op == OP_MTHI) hi <= rs_val;
                else               lo <= rs_val;
            end
            if (accept_op) begin
                op_q         <= op;
                cnt          <= CW'(WIDTH);
                dividend_raw <= rs_val;
                div_zero     <= (rt_val == '0);
                neg_q        <= sign_a ^ sign_b;
                neg_r        <= sign_a && op_is_div(op);
                // Divide runs {rem, quo} with dividend in the low half;
                // multiply runs {acc, multiplier} with the multiplier low.
                if (op_is_div(op)) begin
                    part    <= {{WIDTH{1'b0}}, abs_a};
                    operand <= abs_b;
                end else begin
                    part    <= {{WIDTH{1'b0}}, abs_b};
                    operand <= abs_a;
                end
            end
            if ((state == S_CALC) && !flush) begin
                part <= {part_nx[2*WIDTH-1:1], part_nx[0] | q_bit};
                cnt  <= cnt - CW'(1);
            end
            if ((state == S_FIXUP) && !flush) begin
                hi   <= hi_fix;
                lo   <= lo_fix;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - randomized self-checking bench for mips_muldiv_unit
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, flush;
    logic [3:0]  opr;
    logic [31:0] rsv, rtv;
    int          sel;

    logic        start32, start16;
    logic        ready32, busy32, done32;
    logic [31:0] hi32, lo32;
    logic        ready16, busy16, done16;
    logic [15:0] hi16, lo16;

    logic [31:0] hi_m, lo_m;
    logic        ready_m, busy_m, done_m;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_hi [2];
    logic [31:0] exp_lo [2];

    always #5 clk = ~clk;

    assign start32 = start && (sel == 0);
    assign start16 = start && (sel == 1);
    assign hi_m    = (sel == 0) ? hi32 : {16'h0, hi16};
    assign lo_m    = (sel == 0) ? lo32 : {16'h0, lo16};
    assign ready_m = (sel == 0) ? ready32 : ready16;
    assign busy_m  = (sel == 0) ? busy32 : busy16;
    assign done_m  = (sel == 0) ? done32 : done16;

    mips_muldiv_unit #(.WIDTH(32), .ENABLE_MAC(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start32), .op(opr),
        .rs_val(rsv), .rt_val(rtv), .flush(flush),
        .ready(ready32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    mips_muldiv_unit #(.WIDTH(16), .ENABLE_MAC(1'b0)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(opr),
        .rs_val(rsv[15:0]), .rt_val(rtv[15:0]), .flush(flush),
        .ready(ready16), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Architectural result of one op on a w-bit machine, from plain arithmetic.
    // Returns {hi, lo} zero-extended into two 32-bit halves.
    function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] a_in,
                                           input logic [31:0] b_in, input logic [31:0] hi_in,
                                           input logic [31:0] lo_in, input int w);
        logic [63:0] mw, m2, a, b, hl, p, rh, rl;
        longint      sa, sb;
        mw = (64'd1 << w) - 64'd1;
        m2 = (w >= 32) ? {64{1'b1}} : ((64'd1 << (2 * w)) - 64'd1);
        a  = {32'h0, a_in} & mw;
        b  = {32'h0, b_in} & mw;
        hl = (({32'h0, hi_in} & mw) << w) | ({32'h0, lo_in} & mw);
        sa = (((a >> (w - 1)) & 64'd1) != 64'd0) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = (((b >> (w - 1)) & 64'd1) != 64'd0) ? longint'(b) - (longint'(1) << w) : longint'(b);
        if (o == OP_MULT || o == OP_MADD || o == OP_MSUB) p = 64'(sa * sb);
        else                                              p = a * b;
        case (o)
            OP_MULT, OP_MULTU: hl = p & m2;
            OP_MADD, OP_MADDU: hl = (hl + p) & m2;
            OP_MSUB, OP_MSUBU: hl = (hl - p) & m2;
            OP_DIVU: begin
                if (b == 64'd0) hl = (a << w) | mw;
                else            hl = ((a % b) << w) | (a / b);
            end
            OP_DIV: begin
                if (b == 64'd0)                                          hl = (a << w) | mw;
                else if (sa == -(longint'(1) << (w - 1)) && sb == -64'sd1) hl = a;
                else hl = ((64'(sa % sb) & mw) << w) | (64'(sa / sb) & mw);
            end
            OP_MTHI: hl = (hl & mw) | (a << w);
            OP_MTLO: hl = (hl & ~mw) | a;
            default: ;
        endcase
        rh = (hl >> w) & mw;
        rl = hl & mw;
        return {rh[31:0], rl[31:0]};
    endfunction

    task automatic run_op(input int s, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        int          w;
        int          n;
        logic        mac, accepted;
        logic [63:0] r;
        w        = (s == 0) ? 32 : 16;
        mac      = (o >= OP_MADD) && (o <= OP_MSUBU);
        accepted = (o <= OP_MSUBU) && !(s == 1 && mac);
        @(negedge clk);
        sel = s; start = 1'b1; opr = o; rsv = a; rtv = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (o == OP_MTHI || o == OP_MTLO) begin
            r = ref_op(o, a, b, exp_hi[s], exp_lo[s], w);
            exp_hi[s] = r[63:32];
            exp_lo[s] = r[31:0];
            check_val({tag, "_mt_ready"}, 64'(ready_m), 64'd1);
        end else if (!accepted) begin
            check_val({tag, "_ign_ready"}, 64'(ready_m), 64'd1);
        end else begin
            check_val({tag, "_busy"}, 64'(busy_m), 64'd1);
            n = 0;
            while (n < 200) begin
                @(posedge clk);
                #1;
                n++;
                if (done_m) break;
            end
            check_val({tag, "_latency"}, 64'(n), 64'(w + 1));
            r = ref_op(o, a, b, exp_hi[s], exp_lo[s], w);
            exp_hi[s] = r[63:32];
            exp_lo[s] = r[31:0];
            check_val({tag, "_ready"}, 64'(ready_m), 64'd1);
        end
        check_val({tag, "_hi"}, 64'(hi_m), 64'(exp_hi[s]));
        check_val({tag, "_lo"}, 64'(lo_m), 64'(exp_lo[s]));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_8000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        reset = 1'b0; start = 1'b0; flush = 1'b0; sel = 0;
        opr = 4'd0; rsv = '0; rtv = '0;
        exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rst_hi", 64'(hi32), 64'd0);
        check_val("rst_lo", 64'(lo32), 64'd0);
        check_val("rst_ready", 64'(ready32), 64'd1);
        check_val("rst_busy", 64'(busy32), 64'd0);
        check_val("rst_done", 64'(done32), 64'd0);

        // Signed multiply, result values and single-cycle done pulse
        run_op(0, OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult");
        check_val("mult_hi_k", 64'(hi32), 64'hFFFF_FFFF);
        check_val("mult_lo_k", 64'(lo32), 64'hFFFF_FFEB);
        @(posedge clk);
        #1;
        check_val("mult_done_pulse", 64'(done32), 64'd0);

        run_op(0, OP_DIVU, 32'd100, 32'd7, "divu");
        check_val("divu_k", {32'h0, hi32, lo32} >> 0, {32'd2, 32'd14});
        run_op(0, OP_DIV, 32'hFFFF_FF9C, 32'd7, "div_neg");
        check_val("div_neg_k", {hi32, lo32}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        run_op(0, OP_DIV, 32'd5, 32'd0, "div_zero");
        check_val("div_zero_k", {hi32, lo32}, {32'd5, 32'hFFFF_FFFF});
        run_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check_val("div_ovf_k", {hi32, lo32}, {32'd0, 32'h8000_0000});

        run_op(0, OP_MTHI, 32'd1, 32'd0, "mthi");
        run_op(0, OP_MTLO, 32'd0, 32'd0, "mtlo");
        run_op(0, OP_MADDU, 32'hFFFF_FFFF, 32'd2, "maddu");
        check_val("maddu_k", {hi32, lo32}, 64'h0000_0002_FFFF_FFFE);
        run_op(0, OP_MSUB, 32'd1, 32'd1, "msub");
        check_val("msub_k", {hi32, lo32}, 64'h0000_0002_FFFF_FFFD);

        // Flush at cycle 10 of a multiply
        @(negedge clk);
        sel = 0; start = 1'b1; opr = OP_MULT; rsv = 32'd123; rtv = 32'd456;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_val("flush_ready", 64'(ready32), 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done32) seen++;
        end
        check_val("flush_nodone", 64'(seen), 64'd0);
        check_val("flush_hilo", {hi32, lo32}, {exp_hi[0], exp_lo[0]});

        // start together with flush in IDLE: nothing accepted
        @(negedge clk);
        start = 1'b1; flush = 1'b1; opr = OP_MTHI; rsv = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check_val("idle_flush_hi", 64'(hi32), 64'(exp_hi[0]));
        @(negedge clk);
        start = 1'b1; flush = 1'b1; opr = OP_MULT; rsv = 32'd3; rtv = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check_val("idle_flush_ready", 64'(ready32), 64'd1);

        // start while busy is dropped
        @(negedge clk);
        start = 1'b1; opr = OP_MULTU; rsv = 32'd3; rtv = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; opr = OP_MTHI; rsv = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (n < 100 && !done32) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("busy_start_done", 64'(done32), 64'd1);
        check_val("busy_start_res", {hi32, lo32}, 64'd15);
        exp_hi[0] = 32'd0; exp_lo[0] = 32'd15;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done32 || !ready32) seen++;
        end
        check_val("busy_start_noqueue", 64'(seen), 64'd0);
        check_val("busy_start_hi", 64'(hi32), 64'd0);

        // WIDTH=16 instance, MAC disabled
        run_op(1, OP_MULT, 32'h0000_FFFD, 32'd7, "w16_mult");
        check_val("w16_mult_k", {hi16, lo16}, {16'hFFFF, 16'hFFEB});
        run_op(1, OP_DIVU, 32'd100, 32'd7, "w16_divu");
        check_val("w16_divu_k", {hi16, lo16}, {16'd2, 16'd14});
        run_op(1, OP_DIV, 32'h0000_FF9C, 32'd7, "w16_div");
        check_val("w16_div_k", {hi16, lo16}, {16'hFFFE, 16'hFFF2});
        run_op(1, OP_MADD, 32'd9, 32'd9, "w16_madd_off");

        // Async reset in the middle of CALC
        @(negedge clk);
        sel = 0; start = 1'b1; opr = OP_DIV; rsv = 32'd1000; rtv = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_hi", 64'(hi32), 64'd0);
        check_val("arst_lo", 64'(lo32), 64'd0);
        check_val("arst_ready", 64'(ready32), 64'd1);
        check_val("arst_done", 64'(done32), 64'd0);
        check_val("arst_w16", {hi16, lo16}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;

        // Random ops on both widths, issued back to back
        for (int i = 0; i < 48; i++) begin
            run_op((i % 4 == 3) ? 1 : 0, 4'($urandom_range(0, 9)), pick(), pick(), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
